// File: rtl/lcg_csa_pkg.sv
// Shared types and constants for the carry-save LCG first stage.
// Optional radix-4 mode is selected by CSA_RADIX4_EN.
package lcg_csa_pkg;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned STEP_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : lcg_csa_pkg

// File: rtl/lcg_csa_first_stage_csa_row.sv
// Combinational WIDTH-bit 3:2 compressor; c_o carries weight 2^(i+1).
module csa_row #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] z_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] c_o
);

    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);

endmodule : csa_row

// File: rtl/lcg_csa_first_stage.sv
// Iterative carry-save a*x + c (mod 2^WIDTH) producer with ready/valid on both sides.
// Define CSA_RADIX4_EN to retire two multiplier bits per RUN cycle.
module lcg_csa_first_stage #(
    parameter int unsigned WIDTH = lcg_csa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_x,
    input  logic [WIDTH-1:0] inc_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] si,
    output logic [WIDTH-1:0] cy
);

    import lcg_csa_pkg::*;

`ifdef CSA_RADIX4_EN
    localparam int unsigned STEP_INC = 2;
`else
    localparam int unsigned STEP_INC = 1;
`endif
    localparam int unsigned LAST_STEP = WIDTH - STEP_INC;

    state_e              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    m_q;
    logic [WIDTH-1:0]    s_q;
    logic [WIDTH-1:0]    c_q;
    logic [STEP_W-1:0]   step_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [WIDTH-1:0]    c2;
    logic [WIDTH-1:0]    pp0;
    logic [WIDTH-1:0]    s0;
    logic [WIDTH-1:0]    c0;
    logic [WIDTH-1:0]    s_d;
    logic [WIDTH-1:0]    c_d;
    logic [WIDTH-1:0]    m_d;

    // Carry vector realigned to sum weight; bit WIDTH-1 of C falls off at 2^WIDTH.
    assign c2  = {c_q[WIDTH-2:0], 1'b0};
    assign pp0 = m_q[0] ? (a_q << step_q) : '0;

    csa_row #(.WIDTH(WIDTH)) u_row0 (
        .x_i (s_q),
        .y_i (c2),
        .z_i (pp0),
        .s_o (s0),
        .c_o (c0)
    );

`ifdef CSA_RADIX4_EN
    logic [WIDTH-1:0] pp1;
    logic [WIDTH-1:0] c0_sh;

    assign pp1   = m_q[1] ? (a_q << (step_q + STEP_W'(1))) : '0;
    assign c0_sh = {c0[WIDTH-2:0], 1'b0};

    csa_row #(.WIDTH(WIDTH)) u_row1 (
        .x_i (s0),
        .y_i (c0_sh),
        .z_i (pp1),
        .s_o (s_d),
        .c_o (c_d)
    );

    assign m_d = m_q >> 2;
`else
    assign s_d = s0;
    assign c_d = c0;
    assign m_d = m_q >> 1;
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            m_q         <= '0;
            s_q         <= '0;
            c_q         <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= RUN;
                        a_q        <= mul_a;
                        m_q        <= mul_x;
                        s_q        <= inc_c;
                        c_q        <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    s_q    <= s_d;
                    c_q    <= c_d;
                    m_q    <= m_d;
                    step_q <= step_q + STEP_W'(STEP_INC);
                    if (step_q == STEP_W'(LAST_STEP)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign si        = s_q;
    assign cy        = c_q;

endmodule : lcg_csa_first_stage

// File: tb/tb_lcg_csa_first_stage.sv
// Directed table-driven bench for lcg_csa_first_stage (radix-4 when CSA_RADIX4_EN is defined).
module tb_lcg_csa_first_stage;

`ifdef CSA_RADIX4_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] mul_a;
    logic [63:0] mul_x;
    logic [63:0] inc_c;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] si;
    logic [63:0] cy;

    int n_checks = 0;
    int n_pass   = 0;

    lcg_csa_first_stage #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_x     (mul_x),
        .inc_c     (inc_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .si        (si),
        .cy        (cy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] x;
        logic [63:0] c;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    function automatic logic [63:0] resolved();
        return si + (cy << 1);
    endfunction

    // Waits (bounded) for in_ready, then presents one request for one accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] x, input logic [63:0] c);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
        mul_a = a; mul_x = x; inc_c = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] hold_si;
        logic [63:0] hold_cy;
        logic        bad;
        int          lat;
        int          acc_cyc[3];
        int          n_acc;
        int          n_res;
        int          cyc;

        vecs[0] = '{64'd3, 64'd5, 64'd0, 64'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
        vecs[2] = '{64'd6364136223846793005, 64'd1, 64'd1442695040888963407, 64'd7806831264735756412};
        vecs[3] = '{64'd0, 64'd123, 64'd42, 64'd42};
        vecs[4] = '{64'd5, 64'd0, 64'd99, 64'd99};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd3, 64'd0, 64'h8000_0000_0000_0000};
        vecs[6] = '{64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[7] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd5, 64'd5};
        vecs[8] = '{64'd12345, 64'd6789, 64'd1000, 64'd83811205};
        vecs[9] = '{64'd7, 64'd9, 64'd1, 64'd64};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mul_a = '0; mul_x = '0; inc_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_si", si, 64'd0);
        check("rst_cy", cy, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single transactions from the table.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].x, vecs[i].c);
            check($sformatf("busy_in_ready[%0d]", i), 64'(in_ready), 64'd0);
            wait_out(lat);
            check($sformatf("latency[%0d]", i), 64'(lat), 64'(LAT));
            res = resolved();
            check($sformatf("result[%0d]", i), res, vecs[i].exp);
            handshake();
            check($sformatf("post_hs_in_ready[%0d]", i), 64'(in_ready), 64'd1);
        end

        // Backpressure: outputs hold and a stray request is ignored.
        issue(64'd3, 64'd5, 64'd0);
        wait_out(lat);
        hold_si = si; hold_cy = cy; bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                mul_a = 64'd11; mul_x = 64'd13; inc_c = 64'd17; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (si !== hold_si || cy !== hold_cy || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        check("hold_stable", 64'(bad), 64'd0);
        check("hold_result", resolved(), 64'd15);
        handshake();
        bad = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) bad = 1'b1;
        end
        check("ignored_request", 64'(bad), 64'd0);

        // Reset in the middle of RUN drops the result.
        issue(64'd3, 64'd5, 64'd0);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_si", si, 64'd0);
        check("midrun_rst_cy", cy, 64'd0);
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1'b1;
        end
        check("no_stale_out_valid", 64'(bad), 64'd0);
        issue(64'd7, 64'd9, 64'd1);
        wait_out(lat);
        check("post_rst_latency", 64'(lat), 64'(LAT));
        check("post_rst_result", resolved(), 64'd64);
        handshake();

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        n_acc = 0; n_res = 0; cyc = 0;
        while (n_res < 3 && cyc < 400) begin
            if (out_valid) begin
                check($sformatf("b2b_result[%0d]", n_res), resolved(), vecs[n_res].exp);
                n_res++;
            end
            if (in_ready) begin
                if (n_acc < 3) begin
                    mul_a = vecs[n_acc].a; mul_x = vecs[n_acc].x; inc_c = vecs[n_acc].c;
                    in_valid = 1'b1;
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 64'(n_res), 64'd3);
        check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(LAT + 2));
        check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(LAT + 2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lcg_csa_first_stage

// File: doc/lcg_csa_first_stage.md
# lcg_csa_first_stage

Sequential carry-save multiply-accumulate front end for the MDCLCG datapath. It computes x' = a·x + c mod 2^64 and holds the result in redundant form as a sum vector and a carry vector. The block is the producer for the 64-bit carry-propagate second stage, which resolves `si + (cy<<1)` with carry-in 0. It performs one iterative multiplication per request and uses ready/valid handshakes on both sides.

## Interface
Parameters:
- WIDTH, 64, datapath width; the second stage fixes it at 64.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- mul_a  in  WIDTH  multiplier constant a.
- mul_x  in  WIDTH  current state x.
- inc_c  in  WIDTH  additive constant c.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- si  out  WIDTH  sum vector; weight 2^i.
- cy  out  WIDTH  carry vector; weight 2^(i+1).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `in_valid & in_ready`:
  - latch mul_a into A;
  - latch mul_x into shift register M;
  - set S = inc_c, C = 0, step = 0.
- RUN, each cycle:
  - pp = M[0] ? (A << step) : 0, truncated to WIDTH bits.
  - C2 = {C[WIDTH-2:0], 1'b0}.
  - S ← S ^ C2 ^ pp.
  - C ← majority(S, C2, pp).
  - M ← M >> 1; step ← step + 1.
- Invariant: S + 2C ≡ c + a·(x mod 2^step) (mod 2^64). Bits at or above 2^64 are discarded.
- RUN → DONE after the step-63 update.
- DONE → IDLE on `out_valid & out_ready`.
- si = S and cy = C, driven directly from registers.
- si and cy are stable and unchanged while out_valid is high and out_ready is low.
- While not in IDLE, in_valid is ignored; no request is queued.
- Reset values: state = IDLE, S = C = A = M = 0, step = 0, in_ready = 1, out_valid = 0, si = cy = 0.
- Reset asserted mid-RUN or in DONE: return to IDLE immediately and drop the result. No out_valid pulse follows.
- mul_x = 0 or mul_a = 0: the block still takes the full latency, and si + 2cy = inc_c.

## Timing
- Request accepted at edge k.
- RUN occupies edges k+1 … k+64 (radix-2).
- out_valid goes high after edge k+64 and stays high until the handshake.
- Output handshake at edge j: in_ready rises after edge j, and the next request can be accepted at edge j+1 at the earliest.
- Throughput: one result per 66 cycles with out_ready held high.
- in_ready and out_valid are registered-state decodes, with no combinational path from inputs.

## Configuration
- CSA_RADIX4_EN defined:
  - each RUN cycle consumes M[1:0];
  - it adds two partial products through two chained CSA rows (pp0 = A<<step, pp1 = A<<(step+1));
  - step advances by 2 and M shifts by 2;
  - RUN lasts 32 cycles, and out_valid rises after edge k+32.
- CSA_RADIX4_EN undefined: radix-2 operation, 64 RUN cycles.
- The final numeric value of si + 2cy is identical in both modes. The individual si and cy vectors may differ between modes.

## Structure
- Package lcg_csa_pkg holds:
  - localparam WIDTH = 64;
  - state enum {IDLE, RUN, DONE};
  - step counter width 7.
- Sub-module csa_row: purely combinational WIDTH-bit 3:2 compressor with inputs (x, y, z) and outputs (s, c). It is instantiated once, or twice under CSA_RADIX4_EN.
- The reference model checks (si + (cy<<1)) mod 2^64, i.e. what the second stage produces in S[63:0].

## Test plan
- a=3, x=5, c=0 → out_valid after 64 cycles (32 with radix-4); (si + 2cy) mod 2^64 = 15.
- a=x=2^64−1, c=0 → resolved value 1. Carries past bit 63 are discarded.
- a=6364136223846793005, x=1, c=1442695040888963407 → resolved value 7806831264735756412.
- Hold out_ready low for 10 cycles after out_valid rises → si and cy remain constant, in_ready stays 0, and a pulse on in_valid is ignored.
- Assert rst_n low at RUN cycle 30, release it, then issue a=7, x=9, c=1 → no stale out_valid; the next result is 64 and all outputs are 0 during reset.
- Back-to-back requests with out_ready tied high → 66 cycles between accepted requests (34 with radix-4), and each result is correct.
